// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Holds the NOP encoding, the PC step, the FSM encoding and the queue entry layout.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular storage for fetched entries: head/tail pointers, occupancy count,
// push/pop and a synchronous clear that discards everything in one edge.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head_reg;
    logic [AW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;

    // Storage is never reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two
    // makes the natural overflow the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[head_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks the fetch pointer through instruction memory,
// buffers {pc, word} pairs for decode and flushes on an execute redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [31:0]            imem_a,
    input  logic [31:0]            imem_rd,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   stall_D,
    output logic                   instr_valid,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [31:0]     ALIGN_MASK = 32'hFFFF_FFFC;

    fq_state_e   state_reg;
    fq_state_e   state_next;
    logic [31:0] fpc_reg;
    logic [31:0] fpc_next;
    logic        run;
    logic        push;
    logic        pop;
    logic        clear;
    fq_entry_t   head_entry;
    fq_entry_t   tail_entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        run        = 1'b0;
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  run        = 1'b1;
            default: state_next = ST_BOOT;
        endcase
    end

    // Redirect wins over push and pop: the queue empties and fetch restarts
    // at the word-aligned target; the popped head this cycle is still reported.
    assign pop   = instr_valid & ~stall_D;
    assign clear = run & redirect;
    assign push  = run & ~redirect & ((count < FULL_COUNT) | pop);

    always_comb begin
        fpc_next = fpc_reg;
        if (clear) begin
            fpc_next = redirect_pc & ALIGN_MASK;
        end else if (push) begin
            fpc_next = fpc_reg + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_reg <= RESET_PC;
        end else begin
            fpc_reg <= fpc_next;
        end
    end

    assign imem_a     = fpc_reg;
    assign tail_entry = '{pc: fpc_reg, word: imem_rd};

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fq_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (tail_entry),
        .rdata (head_entry),
        .count (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head_entry.word : NOP_INSTR;
    assign instr_pc    = instr_valid ? head_entry.pc   : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues the expected {pc} stream,
// a negedge monitor checks every reported pop; inline checks cover timing points.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_D     (stall_D),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0001;
    endfunction

    assign imem_rd = imem_word(imem_a);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expect_pcs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(first + 32'(4 * i));
        end
    endtask

    // Scoreboard monitor: every decode acceptance must match the next expected pc.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset && instr_valid && !stall_D) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc %h expected none at %0t", instr_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", instr_pc, e);
                chk("pop_instr", instr, imem_word(e));
            end
        end
    end

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall_D     = 1'b1;

        // Reset state
        repeat (2) tick();
        settle();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_imem_a", imem_a, 32'h0);

        // Release and stream: six pops 0x0..0x14
        expect_pcs(32'h0, 6);
        tick(); reset = 1'b1; stall_D = 1'b0;
        settle();
        chk("boot_valid", 32'(instr_valid), 32'd0);
        chk("boot_imem_a", imem_a, 32'h0);
        tick(); settle();
        chk("c1_valid", 32'(instr_valid), 32'd0);
        tick(); settle();
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_pc", instr_pc, 32'h0);
        repeat (5) tick();
        tick(); stall_D = 1'b1;

        // Redirect while stalled with three entries
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0;
        settle();
        chk("pre_redir_count", 32'(count), 32'd3);
        chk("pre_redir_pc", instr_pc, 32'h18);
        tick(); redirect = 1'b0;
        settle();
        chk("post_redir_valid", 32'(instr_valid), 32'd0);
        chk("post_redir_count", 32'(count), 32'd0);
        chk("post_redir_imem_a", imem_a, 32'h0);
        tick(); settle();
        chk("stall_hold_pc", instr_pc, 32'h0);
        repeat (6) tick();
        settle();
        chk("sat_count", 32'(count), 32'd4);
        chk("sat_imem_a", imem_a, 32'h10);
        chk("sat_pc", instr_pc, 32'h0);

        // Release from full: consecutive 0x0..0x10, count stays full
        expect_pcs(32'h0, 5);
        tick(); stall_D = 1'b0; settle();
        chk("rel_pc0", instr_pc, 32'h0);
        chk("rel_count0", 32'(count), 32'd4);
        tick(); settle();
        chk("rel_pc1", instr_pc, 32'h4);
        chk("rel_count1", 32'(count), 32'd4);
        tick(); settle();
        chk("rel_pc2", instr_pc, 32'h8);
        tick(); settle();
        chk("rel_pc3", instr_pc, 32'hC);
        tick(); settle();
        chk("rel_pc4", instr_pc, 32'h10);

        // Full and stalled: frozen
        tick(); stall_D = 1'b1; settle();
        chk("frz_pc_a", instr_pc, 32'h14);
        chk("frz_imem_a_a", imem_a, 32'h24);
        chk("frz_count_a", 32'(count), 32'd4);
        tick(); settle();
        chk("frz_pc_b", instr_pc, 32'h14);
        chk("frz_imem_a_b", imem_a, 32'h24);

        // Redirect from full while decode accepts the head
        exp_q.push_back(32'h14);
        expect_pcs(32'h200, 2);
        tick(); redirect = 1'b1; redirect_pc = 32'h203; stall_D = 1'b0;
        settle();
        chk("redir_valid", 32'(instr_valid), 32'd1);
        tick(); redirect = 1'b0; settle();
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_imem_a", imem_a, 32'h200);
        chk("redir_valid_next", 32'(instr_valid), 32'd0);
        tick(); settle();
        chk("redir_pc", instr_pc, 32'h200);
        tick();
        tick(); stall_D = 1'b1;

        // Redirect near the top of the address space
        tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        settle();
        chk("wrap_pre_count", 32'(count), 32'd2);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        tick(); redirect = 1'b0; stall_D = 1'b0; settle();
        chk("wrap_valid", 32'(instr_valid), 32'd0);
        chk("wrap_imem_a", imem_a, 32'hFFFF_FFF8);
        tick(); settle();
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        tick(); settle();
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_imem_a0", imem_a, 32'h0);
        tick(); settle();
        chk("wrap_pc2", instr_pc, 32'h0);
        tick();
        tick(); stall_D = 1'b1;
        repeat (3) tick();
        settle();
        chk("refill_count", 32'(count), 32'd4);

        // Reset pulse while full and streaming
        exp_q.push_back(32'h8);
        tick(); stall_D = 1'b0; settle();
        chk("stream_pc", instr_pc, 32'h8);
        tick(); reset = 1'b0; settle();
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, 32'h0000_0013);
        chk("mid_rst_pc", instr_pc, 32'h0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_imem_a", imem_a, 32'h0);
        expect_pcs(32'h0, 2);
        tick(); reset = 1'b1; settle();
        chk("reboot_valid", 32'(instr_valid), 32'd0);
        tick(); settle();
        chk("reboot_valid1", 32'(instr_valid), 32'd0);
        chk("reboot_imem_a", imem_a, 32'h0);
        tick(); settle();
        chk("reboot_pc", instr_pc, 32'h0);
        tick();
        tick(); stall_D = 1'b1;
        repeat (3) tick();
        settle();
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 imem_a  out  32  fetch address to instruction memory (combinational read).
REQ-006 imem_rd  in  32  instruction word for imem_a, valid same cycle.
REQ-007 redirect  in  1  branch/jump/trap redirect from execute; flushes queue.
REQ-008 redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-009 stall_D  in  1  decode not accepting; head entry held.
REQ-010 instr_valid  out  1  head entry valid.
REQ-011 instr  out  32  head instruction word.
REQ-012 instr_pc  out  32  address of head instruction.
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 FSM states BOOT and RUN; reset enters BOOT; BOOT -> RUN after one clock; RUN is held until reset.
REQ-015 In BOOT no push and no pop; imem_a = RESET_PC.
REQ-016 imem_a shall equal the fetch pointer fpc at all times.
REQ-017 pop = instr_valid & ~stall_D.
REQ-018 In RUN, push = ~redirect & ((count < DEPTH) | pop); push writes {fpc, imem_rd} at tail and sets fpc <= fpc + 4.
REQ-019 fpc addition is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 Simultaneous push and pop when full shall be allowed; count unchanged.
REQ-021 instr_valid = (count != 0); instr and instr_pc driven from head entry, 32'h0000_0013 (NOP) and 0 when empty.
REQ-022 Head-to-output latency: an entry pushed at edge N is visible on instr at cycle N+1; no combinational path from imem_rd to instr.
REQ-023 redirect=1 (any state except BOOT) shall, at the next edge, set count to 0, discard all entries, and set fpc <= {redirect_pc[31:2], 2'b00}; redirect has priority over push and pop.
REQ-024 During the redirect cycle, pop of the current head shall still be reported (instr_valid unaffected combinationally); the entry is simply discarded at the edge.
REQ-025 Cycle after redirect: imem_a = new fpc and a push occurs (queue empty).
REQ-026 stall_D=1 with queue full: no push, fpc frozen, outputs stable.
REQ-027 Head/tail pointers wrap modulo DEPTH.

Reset
REQ-028 reset low asynchronously forces: state BOOT, count 0, head/tail 0, fpc RESET_PC, instr_valid 0, instr NOP, instr_pc 0.
REQ-029 Reset asserted mid-operation discards all entries; no partial pushes on release.
REQ-030 Storage array contents need not be reset.

Structure
REQ-031 Shared package holds NOP encoding, FSM state encoding, and the PC increment constant (4).
REQ-032 One sub-module, fq_fifo (parameterised storage with head/tail/count, push/pop/clear); FSM and fpc stay in fetch_queue.

Verification
REQ-033 Reset release, stall_D=0, imem returns addr-based words -> instr_valid rises 2 cycles after release; instr_pc 0,4,8,... one per cycle.
REQ-034 stall_D=1 for 8 cycles from empty -> count saturates at 4, imem_a stops at 0x10, instr_pc holds 0x0; release -> 0x0,0x4,0x8,0xC,0x10 in consecutive cycles.
REQ-035 Full queue, redirect=1, redirect_pc=0x203 -> next cycle count=0, imem_a=0x200; following cycle instr_pc=0x200.
REQ-036 Redirect with stall_D=1 and 3 entries -> all discarded; no stale instr_pc appears after redirect.
REQ-037 Redirect to 0xFFFF_FFF8 -> instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 Assert reset for 1 cycle while full and streaming -> outputs reset values immediately; refetch restarts at RESET_PC after BOOT.
